// File: rtl/data_mem_wr_ctrl.sv
// Store-side memory write controller: one store in flight, byte-lane steering,
// alignment check, programmable write latency and a held write response.

module data_mem_wr_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  ofs,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic        mask,
  output logic [7:0]  lane_byte
);
  // Byte index within the right-justified source that lands on this lane.
  logic [1:0] rel;
  assign rel = 2'(LANE) - ofs;

  always_comb begin
    mask = 1'b0;
    case (size)
      2'd0:    mask = (rel == 2'd0);
      2'd1:    mask = (rel <= 2'd1);
      2'd2:    mask = 1'b1;
      default: mask = 1'b0;
    endcase
    lane_byte = mask ? data[{rel, 3'b000} +: 8] : 8'h00;
  end
endmodule

module data_mem_wr_ctrl #(
  parameter int WR_LAT = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_mask,
  output logic [15:0]       wr_cnt
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = (WR_LAT > 0) ? 4'(WR_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, RESP} state_e;

  state_e state, state_nxt;
  logic [3:0] cnt;
  logic       accept, req_err;
  logic [NUM_LANES-1:0]        lane_mask;
  logic [NUM_LANES-1:0][7:0]   lane_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_mem_wr_lane #(.LANE(i)) u_lane (
      .ofs       (req_addr[1:0]),
      .size      (req_size),
      .data      (req_data),
      .mask      (lane_mask[i]),
      .lane_byte (lane_data[i])
    );
  end

  assign req_err = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'd0);

  // Handshake outputs are forced low while reset is held.
  assign req_ready  = rst && (state == IDLE);
  assign resp_valid = rst && (state == RESP);
  assign wr_en      = rst && (state == WRITE);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = req_err ? RESP : ((WR_LAT > 0) ? WAIT : WRITE);
      WAIT:  if (cnt == 4'd0) state_nxt = WRITE;
      WRITE: state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_mask  <= 4'd0;
      resp_err <= 1'b0;
      wr_cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= LAT_M1;
        wr_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        wr_data  <= lane_data;
        wr_mask  <= lane_mask;
        resp_err <= req_err;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == WRITE) wr_cnt <= wr_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_data_mem_wr_ctrl.sv
// Self-checking bench for data_mem_wr_ctrl: directed lane/error/backpressure/reset
// cases plus randomized stores against an arithmetic reference model.

module tb_data_mem_wr_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [15:0] wr_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_cnt = 0;

  data_mem_wr_ctrl #(.WR_LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: mask is a run of size-many ones shifted by the byte offset,
  // data is the low bytes masked off and shifted by 8*offset.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                output logic err, output logic [3:0] m, output logic [31:0] wd);
    int o, n;
    longint full;
    o = int'(a[1:0]);
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    err = (s == 2'd3) || (s == 2'd1 && (o % 2) != 0) || (s == 2'd2 && o != 0);
    m = 4'(((1 << n) - 1) << o);
    full = (longint'(d) & ((64'd1 << (8 * n)) - 1)) << (8 * o);
    wd = full[31:0];
  endfunction

  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input int bp);
    logic err; logic [3:0] m; logic [31:0] wd;
    int pulses, wr_cyc, resp_cyc;
    model(a, d, s, err, m, wd);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    resp_ready = (bp == 0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    pulses = 0; wr_cyc = -1; resp_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (wr_en) begin
        pulses++;
        wr_cyc = c;
        chk({tag, "_waddr"}, wr_addr, {a[31:2], 2'b00});
        chk({tag, "_wmask"}, 32'(wr_mask), 32'(m));
        chk({tag, "_wdata"}, wr_data, wd);
      end
      if (resp_valid) begin
        resp_cyc = c;
        break;
      end
    end
    if (!err) model_cnt = (model_cnt + 1) % 65536;
    chk({tag, "_resp_cyc"}, 32'(resp_cyc), err ? 32'd1 : 32'(LAT + 2));
    chk({tag, "_pulses"}, 32'(pulses), err ? 32'd0 : 32'd1);
    if (!err) chk({tag, "_wr_cyc"}, 32'(wr_cyc), 32'(LAT + 1));
    chk({tag, "_err"}, 32'(resp_err), 32'(err));
    chk({tag, "_cnt"}, 32'(wr_cnt), 32'(model_cnt));
    if (bp > 0) begin
      for (int c = 0; c < bp; c++) begin
        req_valid = 1'b1; req_addr = $urandom; req_data = $urandom; req_size = 2'd2;
        @(negedge clk);
        chk({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_bp_err"}, 32'(resp_err), 32'(err));
        chk({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_bp_wren"}, 32'(wr_en), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      chk({tag, "_bp_cnt"}, 32'(wr_cnt), 32'(model_cnt));
    end
    @(negedge clk);
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    // Reset held with a pending request.
    req_valid = 1'b1; req_addr = 32'h8000_0000; req_size = 2'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp", 32'(resp_valid), 32'd0);
      chk("rst_wren", 32'(wr_en), 32'd0);
      chk("rst_cnt", 32'(wr_cnt), 32'd0);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rel_ready", 32'(req_ready), 32'd1);

    run_req("word", 32'h8000_0008, 32'hDEAD_BEEF, 2'd2, 0);
    run_req("byte", 32'h8000_0003, 32'h0000_00AB, 2'd0, 0);
    run_req("half", 32'h8000_0002, 32'h0000_1234, 2'd1, 0);
    run_req("mis_half", 32'h8000_0001, 32'h1111_2222, 2'd1, 0);
    run_req("mis_word", 32'h8000_0002, 32'h3333_4444, 2'd2, 0);
    run_req("bad_size", 32'h8000_0000, 32'h5555_6666, 2'd3, 0);
    run_req("bp_ok", 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 5);
    run_req("bp_err", 32'h8000_0013, 32'h0000_7777, 2'd1, 5);

    // Reset asserted one cycle after accept, while waiting.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_data = 32'h0BAD_0BAD; req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    #1;
    chk("mid_rst_wren", 32'(wr_en), 32'd0);
    chk("mid_rst_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("mid_rst_cnt", 32'(wr_cnt), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      chk("mid_rst_nowr", 32'(wr_en), 32'd0);
      chk("mid_rst_noresp", 32'(resp_valid), 32'd0);
    end
    run_req("post_rst", 32'h8000_0024, 32'h1357_9BDF, 2'd2, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rd;
      logic [1:0]  rs;
      ra = $urandom; rd = $urandom; rs = 2'($urandom_range(0, 3));
      run_req("rand", ra, rd, rs, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_wr_ctrl.md
# data_mem_wr_ctrl

Store-side memory controller for the NPC core: accepts one store request at a time from the LSU over a valid/ready handshake. It byte-aligns data, builds the byte-lane mask and rejects misaligned accesses. After a programmable latency it performs the write through the DPI-C `mem_write` call and returns a write response. It is the write-direction counterpart of the instruction-fetch read path and sits between the LSU and the simulated memory.

## Interface
- WR_LAT, 2: wait cycles inserted before the write cycle (0..15)
- ADDR_W, 32: address width
- DATA_W, 32: data width (fixed at 32; 4 byte lanes)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req_valid  input  1  store request valid
- req_ready  output  1  controller can accept a request
- req_addr  input  ADDR_W  byte address
- req_data  input  DATA_W  store data, right-justified (byte in [7:0], half in [15:0])
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- resp_valid  output  1  write response valid
- resp_ready  input  1  LSU accepts response
- resp_err  output  1  1 = request rejected (misaligned/illegal size), no write done
- wr_en  output  1  write strobe; DPI `mem_write(wr_addr, wr_data, wr_mask)` is called on the rising edge ending a cycle with wr_en = 1
- wr_addr  output  ADDR_W  word-aligned address {addr[31:2], 2'b00}
- wr_data  output  DATA_W  lane-shifted data
- wr_mask  output  4  byte-lane enables
- wr_cnt  output  16  completed successful writes, wraps 0xFFFF -> 0

## Operation
- States: IDLE, WAIT, WRITE, RESP.
- IDLE: req_ready = 1. On req_valid, the request is latched: addr, shifted data, mask, err.
  - Error: size 3, or half with addr[0] = 1, or word with addr[1:0] != 0. Next state is RESP.
  - Otherwise: next state is WAIT (WR_LAT > 0, counter loaded with WR_LAT-1) or WRITE (WR_LAT = 0).
- Lane rules, with o = addr[1:0]:
  - byte: mask = 4'b0001 << o, data = req_data[7:0] << 8·o.
  - half: mask = 4'b0011 << o, data = req_data[15:0] << 8·o.
  - word: mask = 4'b1111, data = req_data.
  - Unmasked lanes of wr_data are 0.
- WAIT: the counter decrements each cycle; it moves to WRITE when the counter is 0.
- WRITE: wr_en = 1 for exactly one cycle and the DPI write fires at the end of that cycle. wr_cnt increments at the same edge. Next state is RESP with err = 0.
- RESP: resp_valid = 1 and resp_err holds the latched err. Both are held stable until resp_ready = 1, then the block returns to IDLE.
- req_ready = 0 in WAIT/WRITE/RESP; there are no outstanding or overlapping requests.
- wr_addr/wr_data/wr_mask are held from latch until the next accept. They are only meaningful when wr_en = 1.
- Error requests never assert wr_en and do not change wr_cnt.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, counter = 0, wr_cnt = 0, wr_addr/wr_data/wr_mask = 0, resp_err = 0.
  - req_ready, resp_valid and wr_en are 0 while rst = 0.
  - req_ready rises combinationally once rst = 1.
- Reset mid-operation (WAIT/WRITE/RESP): the pending write is aborted with no DPI call, the response is dropped, and the block returns to IDLE.
- Accept edge = rising edge with req_valid & req_ready.
- Success: wr_en is high in cycle WR_LAT+1 after the accept edge. resp_valid first rises WR_LAT+2 cycles after the accept edge.
- Error: resp_valid rises 1 cycle after the accept edge.
- Minimum issue interval: WR_LAT+3 cycles success, 2 cycles error (resp_ready held 1).
- resp_ready held 0: RESP persists indefinitely and req_ready stays 0.
- req_valid asserted outside IDLE is ignored, not latched.

## Test plan
- Reset: hold rst = 0 for 3 cycles with req_valid = 1. Required: req_ready = resp_valid = wr_en = 0 and wr_cnt = 0. Release: req_ready = 1 in the same cycle.
- Word store, WR_LAT = 2: addr 0x80000008, data 0xDEADBEEF, size 2. Required: wr_en high exactly 3 cycles after accept, with wr_addr 0x80000008, mask 4'b1111, data 0xDEADBEEF. resp_valid at +4 with resp_err = 0, and wr_cnt = 1.
- Byte/half lanes: byte 0xAB at addr 0x80000003 -> mask 4'b1000, wr_data 0xAB000000, wr_addr 0x80000000. Half 0x1234 at addr 0x80000002 -> mask 4'b1100, wr_data 0x12340000.
- Misaligned: half at 0x80000001, word at 0x80000002, and size 3. Required for each: resp_valid 1 cycle after accept with resp_err = 1, no wr_en pulse, and wr_cnt unchanged.
- Backpressure: resp_ready = 0 for 5 cycles. Required: resp_valid/resp_err stable, req_ready = 0 and new req_valid ignored. After resp_ready = 1, req_ready = 1 on the following cycle.
- Reset mid-WAIT: assert rst = 0 one cycle after accept. Required: no wr_en, no DPI write, wr_cnt = 0, and the next request is processed normally after release.
